// File: rtl/systolic_array_pkg.sv
// Shared types for the FP32 matrix-multiply accelerator: word format and control FSM states.
package systolic_array_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_CAPT = 2'd2,
        ST_ACC  = 2'd3
    } state_e;

    localparam word_t FP_QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/fp32_mac.sv
// Combinational FP32 multiply-accumulate: sum = acc + a*b, each step rounded to nearest-even,
// denormal inputs and results flushed to zero.
module fp32_mac
    import systolic_array_pkg::*;
(
    input  word_t acc_i,
    input  word_t a_i,
    input  word_t b_i,
    output word_t sum_c
);

    // Assemble a result from an unbounded exponent, saturating to Inf or flushing to zero.
    function automatic word_t fp_pack(input logic s, input int e, input logic [22:0] frac);
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0)   return {s, 31'd0};
        return {s, 8'(e), frac};
    endfunction

    function automatic word_t fp_mul(input word_t a, input word_t b);
        logic        s;
        logic [7:0]  ea, eb;
        logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        logic [47:0] p;
        logic [23:0] m;
        logic        g, st;
        logic [24:0] mr;
        int          e;
        s      = a[31] ^ b[31];
        ea     = a[30:23];
        eb     = b[30:23];
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);
        a_inf  = (ea == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (eb == 8'hFF) && (b[22:0] == 23'd0);
        a_nan  = (ea == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (eb == 8'hFF) && (b[22:0] != 23'd0);
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return FP_QNAN;
        if (a_inf || b_inf) return {s, 8'hFF, 23'd0};
        if (a_zero || b_zero) return {s, 31'd0};
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(ea) + int'(eb) - 127;
        if (p[47]) begin
            m  = p[47:24];
            g  = p[23];
            st = |p[22:0];
            e  = e + 1;
        end else begin
            m  = p[46:23];
            g  = p[22];
            st = |p[21:0];
        end
        mr = {1'b0, m} + 25'(g & (st | m[0]));
        if (mr[24]) begin
            mr = mr >> 1;
            e  = e + 1;
        end
        return fp_pack(s, e, mr[22:0]);
    endfunction

    function automatic word_t fp_add(input word_t a, input word_t b);
        logic [7:0]  ea, eb;
        logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        word_t       x, y;
        logic [26:0] mx, my, mys, m27;
        logic [53:0] tmp;
        logic [27:0] sum;
        logic [4:0]  dsh;
        logic        g, st, found;
        logic [24:0] mr;
        int          d, e, lz;
        ea     = a[30:23];
        eb     = b[30:23];
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);
        a_inf  = (ea == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (eb == 8'hFF) && (b[22:0] == 23'd0);
        a_nan  = (ea == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (eb == 8'hFF) && (b[22:0] != 23'd0);
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) return FP_QNAN;
        if (a_inf) return {a[31], 8'hFF, 23'd0};
        if (b_inf) return {b[31], 8'hFF, 23'd0};
        if (a_zero && b_zero) return {a[31] & b[31], 31'd0};
        if (a_zero) return b;
        if (b_zero) return a;
        if (a[30:0] >= b[30:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        // Mantissas carry three extra bits: guard, round and a sticky OR of everything below.
        mx  = {1'b1, x[22:0], 3'b000};
        my  = {1'b1, y[22:0], 3'b000};
        d   = int'(x[30:23]) - int'(y[30:23]);
        dsh = (d > 31) ? 5'd31 : 5'(d);
        tmp = {my, 27'd0} >> dsh;
        mys = tmp[53:27];
        mys[0] = mys[0] | (|tmp[26:0]);
        e   = int'(x[30:23]);
        if (x[31] == y[31]) begin
            sum = {1'b0, mx} + {1'b0, mys};
            if (sum[27]) begin
                sum = {1'b0, sum[27:2], sum[1] | sum[0]};
                e   = e + 1;
            end
            m27 = sum[26:0];
        end else begin
            m27 = mx - mys;
            if (m27 == 27'd0) return 32'd0;
            lz    = 0;
            found = 1'b0;
            for (int i = 26; i >= 0; i--) begin
                if (!found) begin
                    if (m27[i]) found = 1'b1;
                    else        lz    = lz + 1;
                end
            end
            m27 = m27 << lz;
            e   = e - lz;
        end
        g  = m27[2];
        st = m27[1] | m27[0];
        mr = {1'b0, m27[26:3]} + 25'(g & (st | m27[3]));
        if (mr[24]) begin
            mr = mr >> 1;
            e  = e + 1;
        end
        return fp_pack(x[31], e, mr[22:0]);
    endfunction

    always_comb sum_c = fp_add(acc_i, fp_mul(a_i, b_i));

endmodule

// File: rtl/top_pd.sv
// Matrix-multiply accelerator: X/W scratchpads, load controller and an N x N output-stationary
// FP32 accumulator array updated by one rank-1 product per run.
module top_pd
    import systolic_array_pkg::*;
#(
    parameter  int unsigned N  = 4,
    parameter  int unsigned AW = 6,
    localparam int unsigned YW = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start_i,
    input  logic [AW-1:0]     base_addr_x,
    input  logic [AW-1:0]     base_addr_w,
    output logic              busy_o,
    output logic              sa_stall_o,
    output word_t [N-1:0]     y_out,
    input  logic [YW-1:0]     y_index,
    input  logic              spad_x_csb0,
    input  logic [AW-1:0]     spad_x_addr0,
    input  word_t             spad_x_din0,
    input  logic              spad_w_csb0,
    input  logic [AW-1:0]     spad_w_addr0,
    input  word_t             spad_w_din0
);

    localparam int unsigned DEPTH = 1 << AW;

    state_e          state_q, state_d;
    logic [YW-1:0]   cnt_q, cnt_d;
    logic [YW-1:0]   rc_q, rc_d;
    logic [AW-1:0]   bx_q, bx_d, bw_q, bw_d;
    logic            rd_vld_q, rd_vld_d;
    logic [YW-1:0]   rd_idx_q, rd_idx_d;
    logic            busy_d, stall_d;
    word_t           x_vec_q [N];
    word_t           x_vec_d [N];
    word_t           w_vec_q [N];
    word_t           w_vec_d [N];
    word_t           y_q     [N][N];
    word_t           y_d     [N][N];
    word_t           mac_sum [N][N];

    word_t           spad_x_mem [DEPTH];
    word_t           spad_w_mem [DEPTH];
    word_t           x_rdata_q, w_rdata_q;
    logic [AW-1:0]   raddr_x_c, raddr_w_c;

    always_comb begin
        raddr_x_c = AW'(bx_q + AW'(cnt_q));
        raddr_w_c = AW'(bw_q + AW'(32'(cnt_q) * N));
    end

    // Scratchpads: port-0 write, port-1 registered read (old data on same-address collision).
    always_ff @(posedge clk) begin
        if (!spad_x_csb0) spad_x_mem[spad_x_addr0] <= spad_x_din0;
        if (!spad_w_csb0) spad_w_mem[spad_w_addr0] <= spad_w_din0;
        x_rdata_q <= spad_x_mem[raddr_x_c];
        w_rdata_q <= spad_w_mem[raddr_w_c];
    end

    for (genvar p = 0; p < N; p++) begin : g_row
        for (genvar q = 0; q < N; q++) begin : g_col
            fp32_mac u_mac (
                .acc_i (y_q[p][q]),
                .a_i   (w_vec_q[p]),
                .b_i   (x_vec_q[q]),
                .sum_c (mac_sum[p][q])
            );
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rc_d     = rc_q;
        bx_d     = bx_q;
        bw_d     = bw_q;
        rd_vld_d = 1'b0;
        rd_idx_d = cnt_q;
        x_vec_d  = x_vec_q;
        w_vec_d  = w_vec_q;
        y_d      = y_q;

        // Read data lands one cycle after its address was issued.
        if (rd_vld_q) begin
            x_vec_d[rd_idx_q] = x_rdata_q;
            w_vec_d[rd_idx_q] = w_rdata_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_READ;
                    cnt_d   = '0;
                    bx_d    = base_addr_x;
                    bw_d    = base_addr_w;
                    if (rc_q == '0) begin
                        for (int p = 0; p < N; p++)
                            for (int q = 0; q < N; q++)
                                y_d[p][q] = 32'd0;
                    end
                end
            end
            ST_READ: begin
                rd_vld_d = 1'b1;
                if (cnt_q == YW'(N - 1)) state_d = ST_CAPT;
                else                     cnt_d   = cnt_q + YW'(1);
            end
            ST_CAPT: state_d = ST_ACC;
            ST_ACC: begin
                y_d     = mac_sum;
                rc_d    = (rc_q == YW'(N - 1)) ? '0 : rc_q + YW'(1);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d  = (state_d != ST_IDLE);
        stall_d = (state_d == ST_ACC);
    end

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rc_q       <= '0;
            bx_q       <= '0;
            bw_q       <= '0;
            rd_vld_q   <= 1'b0;
            rd_idx_q   <= '0;
            busy_o     <= 1'b0;
            sa_stall_o <= 1'b0;
            for (int p = 0; p < N; p++) begin
                x_vec_q[p] <= 32'd0;
                w_vec_q[p] <= 32'd0;
                for (int q = 0; q < N; q++) y_q[p][q] <= 32'd0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rc_q       <= rc_d;
            bx_q       <= bx_d;
            bw_q       <= bw_d;
            rd_vld_q   <= rd_vld_d;
            rd_idx_q   <= rd_idx_d;
            busy_o     <= busy_d;
            sa_stall_o <= stall_d;
            x_vec_q    <= x_vec_d;
            w_vec_q    <= w_vec_d;
            y_q        <= y_d;
        end
    end

    always_comb begin
        for (int q = 0; q < N; q++) y_out[q] = y_q[y_index][q];
    end

endmodule

// File: tb/tb_top_pd.sv
// Directed bench for top_pd: identity, scaled and summed products, run timing, restart,
// address wrap and mid-run reset.
module tb_top_pd;
    import systolic_array_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 6;

    logic           clk = 1'b0;
    logic           n_rst;
    logic           start_i;
    logic [AW-1:0]  base_addr_x, base_addr_w;
    logic           busy_o, sa_stall_o;
    word_t [N-1:0]  y_out;
    logic [1:0]     y_index;
    logic           spad_x_csb0, spad_w_csb0;
    logic [AW-1:0]  spad_x_addr0, spad_w_addr0;
    word_t          spad_x_din0, spad_w_din0;

    int n_chk  = 0;
    int n_pass = 0;

    top_pd #(.N(N), .AW(AW)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .start_i      (start_i),
        .base_addr_x  (base_addr_x),
        .base_addr_w  (base_addr_w),
        .busy_o       (busy_o),
        .sa_stall_o   (sa_stall_o),
        .y_out        (y_out),
        .y_index      (y_index),
        .spad_x_csb0  (spad_x_csb0),
        .spad_x_addr0 (spad_x_addr0),
        .spad_x_din0  (spad_x_din0),
        .spad_w_csb0  (spad_w_csb0),
        .spad_w_addr0 (spad_w_addr0),
        .spad_w_din0  (spad_w_din0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Small non-negative integer to FP32 bit pattern.
    function automatic logic [31:0] itof(input int n);
        int          msb;
        logic [31:0] u;
        if (n == 0) return 32'd0;
        msb = 0;
        for (int i = 0; i < 31; i++) if (n[i]) msb = i;
        u = 32'(n) << (23 - msb);
        return {1'b0, 8'(127 + msb), u[22:0]};
    endfunction

    task automatic write_x(input int a, input word_t v);
        spad_x_csb0 = 1'b0; spad_x_addr0 = AW'(a); spad_x_din0 = v;
        @(negedge clk);
        spad_x_csb0 = 1'b1;
    endtask

    task automatic write_w(input int a, input word_t v);
        spad_w_csb0 = 1'b0; spad_w_addr0 = AW'(a); spad_w_din0 = v;
        @(negedge clk);
        spad_w_csb0 = 1'b1;
    endtask

    // W diagonal (W[p*4+p]) set to v, everything else zero.
    task automatic load_w_diag(input word_t v);
        for (int a = 0; a < 64; a++)
            write_w(a, (a < 16 && (a % 5) == 0) ? v : 32'd0);
    endtask

    task automatic run(input int bx, input int bw);
        int c;
        start_i = 1'b1; base_addr_x = AW'(bx); base_addr_w = AW'(bw);
        @(negedge clk);
        start_i = 1'b0;
        c = 0;
        while (busy_o && c < 20) begin
            @(negedge clk);
            c++;
        end
        if (busy_o) check("run_timeout", {31'd0, busy_o}, 32'd0);
    endtask

    task automatic run_seq();
        for (int i = 0; i < 4; i++) run(4 * i, i);
    endtask

    task automatic check_row(input string tag, input int j, input int e0, input int e1,
                             input int e2, input int e3);
        int e [4];
        e = '{e0, e1, e2, e3};
        y_index = 2'(j);
        #1;
        for (int q = 0; q < 4; q++) check($sformatf("%s_r%0d_c%0d", tag, j, q), y_out[q], itof(e[q]));
    endtask

    int busy_cycles, stall_cycles;
    logic stall_last;

    initial begin
        n_rst = 1'b1; start_i = 1'b0; base_addr_x = '0; base_addr_w = '0; y_index = '0;
        spad_x_csb0 = 1'b1; spad_w_csb0 = 1'b1;
        spad_x_addr0 = '0; spad_w_addr0 = '0; spad_x_din0 = '0; spad_w_din0 = '0;
        repeat (3) @(negedge clk);

        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_stall", {31'd0, sa_stall_o}, 32'd0);
        check_row("rst", 0, 0, 0, 0, 0);
        check_row("rst", 3, 0, 0, 0, 0);
        n_rst = 1'b0;
        @(negedge clk);

        for (int a = 0; a < 64; a++) write_x(a, (a < 16) ? itof(a + 1) : 32'd0);
        load_w_diag(itof(1));

        run_seq();
        check_row("ident", 0, 1, 2, 3, 4);
        check_row("ident", 1, 5, 6, 7, 8);
        check_row("ident", 2, 9, 10, 11, 12);
        check_row("ident", 3, 13, 14, 15, 16);

        // Timed single run (rc back at 0, so Y clears); start pulsed again mid-run.
        start_i = 1'b1; base_addr_x = '0; base_addr_w = '0;
        @(negedge clk);
        start_i = 1'b0;
        busy_cycles = 0; stall_cycles = 0; stall_last = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (!busy_o) break;
            busy_cycles++;
            if (sa_stall_o) stall_cycles++;
            stall_last = sa_stall_o;
            start_i = (c == 1 || c == 2);
            @(negedge clk);
        end
        start_i = 1'b0;
        check("busy_cycles", 32'(busy_cycles), 32'd6);
        check("stall_cycles", 32'(stall_cycles), 32'd1);
        check("stall_last", {31'd0, stall_last}, 32'd1);
        repeat (3) @(negedge clk);
        check("no_extra_run", {31'd0, busy_o}, 32'd0);
        check_row("restart", 0, 1, 2, 3, 4);
        check_row("restart", 1, 0, 0, 0, 0);
        check_row("restart", 3, 0, 0, 0, 0);

        // Reset during READ.
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy_o}, 32'd0);
        check_row("midrst", 0, 0, 0, 0, 0);
        @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);

        load_w_diag(itof(2));
        run_seq();
        check_row("scale2", 0, 2, 4, 6, 8);
        check_row("scale2", 3, 26, 28, 30, 32);

        for (int a = 0; a < 64; a++) write_w(a, (a < 2) ? itof(1) : 32'd0);
        run_seq();
        check_row("sum01", 0, 6, 8, 10, 12);
        check_row("sum01", 1, 0, 0, 0, 0);

        // W column base 63 wraps to 3, 7, 11.
        for (int a = 0; a < 64; a++) write_w(a, 32'd0);
        write_w(63, itof(1));
        write_w(3, itof(2));
        write_w(7, itof(3));
        write_w(11, itof(4));
        run(0, 63);
        check_row("wrap", 0, 1, 2, 3, 4);
        check_row("wrap", 1, 2, 4, 6, 8);
        check_row("wrap", 2, 3, 6, 9, 12);
        check_row("wrap", 3, 4, 8, 12, 16);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
